// File: rtl/iter_komparator_if.sv
// Handshake and result bundle for iter_komparator.
// ITER_KOMPARATOR_MINMAX_EN adds the max_o/min_o result buses.
interface iter_komparator_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             agtb;
    logic             altb;
`ifdef ITER_KOMPARATOR_MINMAX_EN
    logic [WIDTH-1:0] max_o;
    logic [WIDTH-1:0] min_o;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, eq, agtb, altb, max_o, min_o
    );
    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, eq, agtb, altb, max_o, min_o
    );
`else
    modport master (
        output start, signed_mode, a, b,
        input  busy, done, eq, agtb, altb
    );
    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, eq, agtb, altb
    );
`endif
endinterface

// File: rtl/iter_komparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit.
// Optional feature macro: ITER_KOMPARATOR_MINMAX_EN (registered max_o/min_o outputs).
module iter_komparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic clk,
    input logic rst_n,
    iter_komparator_if.slave bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [DIGIT-1:0] dig_a, dig_b;
`ifdef ITER_KOMPARATOR_MINMAX_EN
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
`endif

    // Current digit pair; first step of a signed compare flips the sign bits.
    always_comb begin
        dig_a = sh_a_q[WIDTH-1 -: DIGIT];
        dig_b = sh_b_q[WIDTH-1 -: DIGIT];
        if (sgn_q && (cnt_q == '0)) begin
            dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
            dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
        end
    end

    // Next-state and result logic.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
`ifdef ITER_KOMPARATOR_MINMAX_EN
        opa_d   = opa_q;
        opb_d   = opb_q;
        max_d   = max_q;
        min_d   = min_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    sgn_d   = bus.signed_mode;
                    cnt_d   = '0;
                    state_d = CMP;
`ifdef ITER_KOMPARATOR_MINMAX_EN
                    opa_d   = bus.a;
                    opb_d   = bus.b;
`endif
                end
            end
            CMP: begin
                if (dig_a != dig_b) begin
                    gt_d    = (dig_a > dig_b);
                    lt_d    = (dig_a < dig_b);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef ITER_KOMPARATOR_MINMAX_EN
                    max_d   = (dig_a > dig_b) ? opa_q : opb_q;
                    min_d   = (dig_a > dig_b) ? opb_q : opa_q;
`endif
                end else if (cnt_q == CW'(N - 1)) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef ITER_KOMPARATOR_MINMAX_EN
                    max_d   = opa_q;
                    min_d   = opa_q;
`endif
                end else begin
                    sh_a_d = sh_a_q << DIGIT;
                    sh_b_d = sh_b_q << DIGIT;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifdef ITER_KOMPARATOR_MINMAX_EN
            opa_q   <= '0;
            opb_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
`ifdef ITER_KOMPARATOR_MINMAX_EN
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            max_q   <= max_d;
            min_q   <= min_d;
`endif
        end
    end

    assign bus.busy = (state_q == CMP);
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.agtb = gt_q;
    assign bus.altb = lt_q;
`ifdef ITER_KOMPARATOR_MINMAX_EN
    assign bus.max_o = max_q;
    assign bus.min_o = min_q;
`endif

endmodule
